// File: rtl/bit_serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and the legal
// operand-width range.
package adder_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
interface bit_serial_adder_if #(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );

endinterface

// File: rtl/half_adder.sv
// One-bit half adder cell; two of these form the serial full adder.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic co
);

   assign sum = a ^ b;
   assign co  = a & b;

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle LSB-first adder: one full-adder bit per clock, with a valid/ready
// handshake on operand and result sides.
module bit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   bit_serial_adder_if.slave  bus,
   output logic               busy
);

   localparam int CW = $clog2(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("bit_serial_adder: WIDTH %0d outside legal range", WIDTH);
   end

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic s0, c0, s1, c1;

   half_adder u_ha0 (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .sum (s0),
      .co  (c0)
   );

   half_adder u_ha1 (
      .a   (s0),
      .b   (carry),
      .sum (s1),
      .co  (c1)
   );

   // Operands are only sampled on an accepted handshake, so X on a/b while
   // in_valid is low never reaches the shift registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sr  <= bus.a;
                  b_sr  <= bus.b;
                  carry <= bus.cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum_sr <= {s1, sum_sr[WIDTH-1:1]};
               carry  <= c0 | c1;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign busy          = (state == RUN) || (state == DONE);
   assign bus.sum       = sum_sr;
   assign bus.cout      = carry;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH=8 and WIDTH=16.
module tb_bit_serial_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy8, busy16;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bit_serial_adder_if #(.WIDTH(8))  if8 ();
   bit_serial_adder_if #(.WIDTH(16)) if16 ();

   bit_serial_adder #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8),
      .busy  (busy8)
   );

   bit_serial_adder #(.WIDTH(16)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if16),
      .busy  (busy16)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic rdy(input int w);
      return (w == 16) ? if16.in_ready : if8.in_ready;
   endfunction

   function automatic logic ov(input int w);
      return (w == 16) ? if16.out_valid : if8.out_valid;
   endfunction

   function automatic logic bz(input int w);
      return (w == 16) ? busy16 : busy8;
   endfunction

   function automatic logic [31:0] sm(input int w);
      return (w == 16) ? 32'(if16.sum) : 32'(if8.sum);
   endfunction

   function automatic logic co(input int w);
      return (w == 16) ? if16.cout : if8.cout;
   endfunction

   task automatic drive(input int w, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic c);
      if (w == 16) begin
         if16.in_valid = v;
         if16.a        = a[15:0];
         if16.b        = b[15:0];
         if16.cin      = c;
      end else begin
         if8.in_valid = v;
         if8.a        = a[7:0];
         if8.b        = b[7:0];
         if8.cin      = c;
      end
   endtask

   task automatic set_or(input int w, input logic v);
      if (w == 16) if16.out_ready = v;
      else         if8.out_ready  = v;
   endtask

   // Presents operands for one cycle, then waits for out_valid and checks latency.
   task automatic start(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input string tag);
      int lat;
      @(negedge clk);
      check({tag, " in_ready"}, 64'(rdy(w)), 64'(1'b1));
      drive(w, 1'b1, a, b, c);
      @(negedge clk);
      drive(w, 1'b0, 'x, 'x, 1'bx);
      lat = 0;
      while (!ov(w) && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(w));
   endtask

   task automatic finish(input int w, input logic [31:0] es, input logic ec, input string tag);
      check({tag, " sum"}, 64'(sm(w)), 64'(es));
      check({tag, " cout"}, 64'(co(w)), 64'(ec));
      check({tag, " out_valid"}, 64'(ov(w)), 64'(1'b1));
      set_or(w, 1'b1);
      @(negedge clk);
      set_or(w, 1'b0);
      check({tag, " out_valid drop"}, 64'(ov(w)), 64'(1'b0));
      check({tag, " ready back"}, 64'(rdy(w)), 64'(1'b1));
      check({tag, " busy drop"}, 64'(bz(w)), 64'(1'b0));
   endtask

   task automatic random_run(input int w, input int n);
      logic [31:0] mask, a, b, es;
      logic [32:0] full;
      logic        c;
      mask = (w == 16) ? 32'h0000_FFFF : 32'h0000_00FF;
      for (int i = 0; i < n; i++) begin
         a    = $urandom & mask;
         b    = $urandom & mask;
         c    = 1'($urandom_range(0, 1));
         full = 33'(a) + 33'(b) + 33'(c);
         es   = full[31:0] & mask;
         start(w, a, b, c, $sformatf("rnd%0d_%0d", w, i));
         finish(w, es, full[w], $sformatf("rnd%0d_%0d", w, i));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] ba, bb;
      logic [8:0] bq [$];
      logic [8:0] exp9;
      int         last, viol;

      vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
      vecs[8] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vecs[9] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};

      drive(8, 1'b0, '0, '0, 1'b0);
      drive(16, 1'b0, '0, '0, 1'b0);
      set_or(8, 1'b0);
      set_or(16, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      check("reset in_ready", 64'(if8.in_ready), 64'(1'b1));
      check("reset out_valid", 64'(if8.out_valid), 64'(1'b0));
      check("reset busy", 64'(busy8), 64'(1'b0));
      check("reset sum", 64'(if8.sum), 64'(8'h00));
      check("reset cout", 64'(if8.cout), 64'(1'b0));
      rst_n = 1'b1;

      // out_ready alone in IDLE does nothing
      set_or(8, 1'b1);
      @(negedge clk);
      set_or(8, 1'b0);
      check("idle out_ready busy", 64'(busy8), 64'(1'b0));
      check("idle out_ready out_valid", 64'(if8.out_valid), 64'(1'b0));

      for (int i = 0; i < 10; i++) begin
         start(8, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, $sformatf("vec%0d", i));
         finish(8, 32'(vecs[i].s), vecs[i].co, $sformatf("vec%0d", i));
      end

      // Backpressure in DONE with new operands offered
      start(8, 32'h12, 32'h34, 1'b0, "bp");
      for (int i = 0; i < 5; i++) begin
         drive(8, 1'b1, 32'hFF, 32'hFF, 1'b1);
         @(negedge clk);
         check("bp out_valid", 64'(if8.out_valid), 64'(1'b1));
         check("bp in_ready", 64'(if8.in_ready), 64'(1'b0));
         check("bp sum", 64'(if8.sum), 64'(8'h46));
         check("bp cout", 64'(if8.cout), 64'(1'b0));
      end
      drive(8, 1'b0, '0, '0, 1'b0);
      finish(8, 32'h46, 1'b0, "bp");
      @(negedge clk);
      check("bp no accept", 64'(busy8), 64'(1'b0));

      // Reset three cycles into RUN
      @(negedge clk);
      drive(8, 1'b1, 32'h55, 32'h55, 1'b0);
      @(negedge clk);
      drive(8, 1'b0, '0, '0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_run out_valid", 64'(if8.out_valid), 64'(1'b0));
      check("rst_run in_ready", 64'(if8.in_ready), 64'(1'b1));
      check("rst_run busy", 64'(busy8), 64'(1'b0));
      check("rst_run sum", 64'(if8.sum), 64'(8'h00));
      @(negedge clk);
      rst_n = 1'b1;
      start(8, 32'h10, 32'h20, 1'b0, "post_rst");
      finish(8, 32'h30, 1'b0, "post_rst");

      // Back-to-back with in_valid and out_ready held high
      last = -1;
      viol = 0;
      set_or(8, 1'b1);
      for (int cyc = 0; cyc < 55; cyc++) begin
         @(negedge clk);
         if (busy8 && if8.in_ready) viol++;
         if (if8.out_valid) begin
            exp9 = (bq.size() > 0) ? bq.pop_front() : 9'h1FF;
            check("b2b result", 64'({if8.cout, if8.sum}), 64'(exp9));
         end
         if (if8.in_ready) begin
            if (last >= 0) check("b2b spacing", 64'(cyc - last), 64'(10));
            last = cyc;
            ba = 8'($urandom);
            bb = 8'($urandom);
            drive(8, 1'b1, 32'(ba), 32'(bb), 1'b0);
            bq.push_back(9'(ba) + 9'(bb));
         end
      end
      drive(8, 1'b0, '0, '0, 1'b0);
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (if8.out_valid) begin
            exp9 = (bq.size() > 0) ? bq.pop_front() : 9'h1FF;
            check("b2b drain", 64'({if8.cout, if8.sum}), 64'(exp9));
         end
      end
      set_or(8, 1'b0);
      check("b2b ready_while_busy", 64'(viol), 64'(0));
      check("b2b leftover", 64'(bq.size()), 64'(0));

      random_run(8, 1000);
      random_run(16, 1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
